// File: rtl/dbus_ram_responder_pkg.sv
// Shared data-bus types plus the helpers used by the RAM-backed responder.
package dbus_ram_responder_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  localparam int unsigned DBUS_WORD_BYTES = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } resp_state_t;

  function automatic logic msize_aligned(msize_t size, logic [2:0] off);
    case (size)
      MSIZE1:  return 1'b1;
      MSIZE2:  return ~off[0];
      MSIZE4:  return off[1:0] == 2'b00;
      default: return off == 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/dbus_ram_responder_bram.sv
// Single-port 64-bit word RAM with byte write enables and a 1-cycle read.
// Write-first: the read register captures the post-write word.
module dbus_bram
  import dbus_ram_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_en,
  input  logic [7:0]            i_we,
  input  logic [DEPTH_LOG2-1:0] i_idx,
  input  logic [63:0]           i_wdata,
  output logic [63:0]           o_rdata
);

  logic [63:0] r_mem [1 << DEPTH_LOG2];
  logic [63:0] r_rdata;
  logic [63:0] w_merged;

  always_comb begin
    w_merged = r_mem[i_idx];
    for (int unsigned b = 0; b < DBUS_WORD_BYTES; b++) begin
      if (i_we[b]) w_merged[8*b +: 8] = i_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (i_en && (i_we != '0)) r_mem[i_idx] <= w_merged;
  end

  // Read register idles at zero so rejected or idle cycles present 0 data.
  always_ff @(posedge clk) begin
    if (reset)     r_rdata <= '0;
    else if (i_en) r_rdata <= w_merged;
    else           r_rdata <= '0;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dbus_ram_responder.sv
// Data-bus responder backed by on-chip RAM: one request at a time,
// fixed latency, whole aligned 64-bit words returned.
module dbus_ram_responder
  import dbus_ram_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err_misalign,
  output logic       err_range
);

  localparam logic [63:0] SPAN     = 64'(DBUS_WORD_BYTES) << DEPTH_LOG2;
  localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);

  resp_state_t r_state, w_next;
  logic [3:0]  r_cnt;
  logic [63:0] r_addr, r_data;
  msize_t      r_size;
  logic [7:0]  r_strobe;
  logic        r_addr_ok, r_data_ok, r_err_mis, r_err_rng;

  logic        w_accept, w_enter_resp, w_mem_en, w_mis, w_rng;
  logic [63:0] w_addr, w_data, w_off, w_rdata;
  msize_t      w_size;
  logic [7:0]  w_strobe;
  logic [DEPTH_LOG2-1:0] w_idx;

  assign w_accept = (r_state == ST_IDLE) && dreq.valid;

  // With LATENCY=1 the RAM access happens in the accept cycle, before the
  // request is latched, so decode from the live request while idle.
  assign w_addr   = (r_state == ST_IDLE) ? dreq.addr   : r_addr;
  assign w_size   = (r_state == ST_IDLE) ? dreq.size   : r_size;
  assign w_strobe = (r_state == ST_IDLE) ? dreq.strobe : r_strobe;
  assign w_data   = (r_state == ST_IDLE) ? dreq.data   : r_data;

  assign w_off  = w_addr - BASE_ADDR;
  assign w_rng  = (w_addr < BASE_ADDR) || (w_off >= SPAN);
  assign w_mis  = ~msize_aligned(w_size, w_addr[2:0]);
  assign w_idx  = w_off[DEPTH_LOG2+2:3];

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (dreq.valid) w_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == '0) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_enter_resp = (w_next == ST_RESP);
  assign w_mem_en     = w_enter_resp && !reset && !w_rng && !w_mis;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_size    <= MSIZE1;
      r_strobe  <= '0;
      r_addr_ok <= 1'b0;
      r_data_ok <= 1'b0;
      r_err_mis <= 1'b0;
      r_err_rng <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_addr_ok <= w_accept;
      r_data_ok <= w_enter_resp;
      r_err_mis <= w_enter_resp && w_mis;
      r_err_rng <= w_enter_resp && w_rng;
      if (w_accept) begin
        r_addr   <= dreq.addr;
        r_size   <= dreq.size;
        r_strobe <= dreq.strobe;
        r_data   <= dreq.data;
        r_cnt    <= LAT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  dbus_bram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_bram (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_mem_en),
    .i_we    (w_strobe),
    .i_idx   (w_idx),
    .i_wdata (w_data),
    .o_rdata (w_rdata)
  );

  always_comb begin
    dresp.addr_ok = r_addr_ok;
    dresp.data_ok = r_data_ok;
    dresp.data    = w_rdata;
  end

  assign err_misalign = r_err_mis;
  assign err_range    = r_err_rng;

endmodule

// File: tb/tb_dbus_ram_responder.sv
// Scoreboard bench for dbus_ram_responder (LATENCY=2 main DUT, LATENCY=1 cadence DUT).
module tb_dbus_ram_responder;
  import dbus_ram_responder_pkg::*;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] SPAN = 64'd8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  dbus_req_t  dreq, dreq1;
  dbus_resp_t dresp, dresp1;
  logic       err_mis, err_rng, err_mis1, err_rng1;

  dbus_ram_responder #(.DEPTH_LOG2(10), .LATENCY(2), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .reset(reset), .dreq(dreq), .dresp(dresp),
    .err_misalign(err_mis), .err_range(err_rng)
  );

  dbus_ram_responder #(.DEPTH_LOG2(10), .LATENCY(1), .BASE_ADDR(BASE)) u_dut1 (
    .clk(clk), .reset(reset), .dreq(dreq1), .dresp(dresp1),
    .err_misalign(err_mis1), .err_range(err_rng1)
  );

  typedef struct {
    logic [63:0] data;
    logic        mis;
    logic        rng;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] mdl [1024];

  // Reference: byte-addressed RAM semantics straight from the bus rules.
  function automatic exp_t model(input logic [63:0] a, input msize_t s,
                                 input logic [7:0] st, input logic [63:0] d);
    exp_t        e;
    logic [63:0] nbytes;
    int unsigned w;
    nbytes = 64'd1 << int'(s);
    e.rng  = (a < BASE) || (a >= BASE + SPAN);
    e.mis  = (a % nbytes) != 64'd0;
    e.data = '0;
    if (!e.rng && !e.mis) begin
      w = int'((a - BASE) / 64'd8);
      for (int b = 0; b < 8; b++) if (st[b]) mdl[w][8*b +: 8] = d[8*b +: 8];
      e.data = mdl[w];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && dresp.data_ok) begin
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_data_ok data=%h", dresp.data);
      end else begin
        mon_e = exp_q.pop_front();
        vectors++;
        if ({dresp.data, err_mis, err_rng} !== {mon_e.data, mon_e.mis, mon_e.rng}) begin
          miscompares++;
          $display("FAIL resp got data=%h mis=%b rng=%b expected data=%h mis=%b rng=%b",
                   dresp.data, err_mis, err_rng, mon_e.data, mon_e.mis, mon_e.rng);
        end
      end
    end else if (!reset && (err_mis || err_rng)) begin
      vectors++; miscompares++;
      $display("FAIL err_without_data_ok mis=%b rng=%b expected 0 0", err_mis, err_rng);
    end
  end

  task automatic issue(input logic [63:0] a, input msize_t s,
                       input logic [7:0] st, input logic [63:0] d);
    int cnt;
    exp_q.push_back(model(a, s, st, d));
    @(negedge clk);
    dreq.valid = 1'b1; dreq.addr = a; dreq.size = s; dreq.strobe = st; dreq.data = d;
    @(negedge clk);
    vectors++;
    if (dresp.addr_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL addr_ok got %b expected 1 (addr=%h)", dresp.addr_ok, a);
    end
    dreq.valid  = 1'b0;
    dreq.data   = ~d;
    dreq.strobe = ~st;
    dreq.addr   = a ^ 64'h8;
    cnt = 0;
    while (dresp.data_ok !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    vectors++;
    if (cnt != 2) begin
      miscompares++;
      $display("FAIL latency got %0d cycles after addr_ok expected 2", cnt);
    end
  endtask

  logic [63:0] rnd_a;
  logic [63:0] d1;
  int          n_aok, n_dok;

  initial begin
    dreq  = '0;
    dreq1 = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({dresp, err_mis, err_rng, dresp1, err_mis1, err_rng1} !== '0) begin
      miscompares++;
      $display("FAIL reset_state got aok=%b dok=%b data=%h aok1=%b dok1=%b data1=%h expected all 0",
               dresp.addr_ok, dresp.data_ok, dresp.data, dresp1.addr_ok, dresp1.data_ok, dresp1.data);
    end
    reset = 1'b0;

    for (int i = 0; i < 16; i++) issue(BASE + 64'(8*i), MSIZE8, 8'hFF, {$urandom, $urandom});

    issue(BASE + 64'h10, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788);
    issue(BASE + 64'h10, MSIZE8, 8'h00, 64'h0);
    issue(BASE + 64'h13, MSIZE1, 8'h08, 64'h0000_0000_AB00_0000);
    issue(BASE + 64'h10, MSIZE8, 8'h00, 64'h0);
    issue(BASE + 64'h16, MSIZE4, 8'h00, 64'h0);
    issue(BASE + 64'h16, MSIZE4, 8'hF0, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(BASE + 64'h10, MSIZE8, 8'h00, 64'h0);
    issue(BASE - 64'h8,  MSIZE8, 8'h00, 64'h0);
    issue(BASE - 64'h7,  MSIZE8, 8'hFF, 64'h0);
    issue(BASE + SPAN - 64'h8, MSIZE8, 8'hFF, 64'hCAFE_F00D_1234_5678);
    issue(BASE + SPAN - 64'h8, MSIZE8, 8'h00, 64'h0);
    issue(BASE + SPAN, MSIZE8, 8'hFF, 64'h1);

    // Reset in the first and in the last WAIT cycle of a store.
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      dreq.valid = 1'b1; dreq.addr = BASE + 64'h20; dreq.size = MSIZE8;
      dreq.strobe = 8'hFF; dreq.data = 64'hDEAD_BEEF_0BAD_F00D;
      @(negedge clk);
      dreq.valid = 1'b0;
      repeat (k - 1) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      vectors++;
      if ({dresp, err_mis, err_rng} !== '0) begin
        miscompares++;
        $display("FAIL reset_mid_op(%0d) got aok=%b dok=%b data=%h expected all 0",
                 k, dresp.addr_ok, dresp.data_ok, dresp.data);
      end
      repeat (5) @(negedge clk);
      issue(BASE + 64'h20, MSIZE8, 8'h00, 64'h0);
    end

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0:       rnd_a = BASE - 64'($urandom_range(1, 64));
        1:       rnd_a = BASE + SPAN + 64'($urandom_range(0, 64));
        default: rnd_a = BASE + 64'($urandom_range(0, 127));
      endcase
      issue(rnd_a, msize_t'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom), {$urandom, $urandom});
    end

    // LATENCY=1: valid held high through data_ok re-accepts every other edge.
    d1 = 64'h0F1E_2D3C_4B5A_6978;
    n_aok = 0;
    n_dok = 0;
    @(negedge clk);
    dreq1.valid = 1'b1; dreq1.addr = BASE; dreq1.size = MSIZE8;
    dreq1.strobe = 8'hFF; dreq1.data = d1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dresp1.addr_ok) n_aok++;
      if (dresp1.data_ok) n_dok++;
      vectors++;
      if ({dresp1.addr_ok, dresp1.data_ok} !== ((i % 2 == 0) ? 2'b11 : 2'b00)) begin
        miscompares++;
        $display("FAIL lat1_cadence cycle %0d got aok=%b dok=%b expected %b", i,
                 dresp1.addr_ok, dresp1.data_ok, (i % 2 == 0));
      end
      if (dresp1.data_ok) begin
        vectors++;
        if (dresp1.data !== d1 || err_mis1 || err_rng1) begin
          miscompares++;
          $display("FAIL lat1_data got %h mis=%b rng=%b expected %h 0 0",
                   dresp1.data, err_mis1, err_rng1, d1);
        end
      end
    end
    dreq1.valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (dresp1.addr_ok) n_aok++;
      if (dresp1.data_ok) n_dok++;
    end
    vectors++;
    if (n_aok != 4 || n_dok != 4) begin
      miscompares++;
      $display("FAIL lat1_counts got aok=%0d dok=%0d expected 4 4", n_aok, n_dok);
    end

    repeat (4) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
